// File: rtl/apu_pkg.sv
// Shared definitions for the APU channel register blocks: register offsets, read-back
// constants and the DAC-enable test on an NRx2 envelope byte.
package apu_pkg;

  typedef enum logic [1:0] {
    NR41 = 2'd0,
    NR42 = 2'd1,
    NR43 = 2'd2,
    NR44 = 2'd3
  } reg_offset_t;

  // Write-only bits read back as 1s.
  localparam logic [7:0] RD_NR41_VAL = 8'hFF;
  localparam logic [7:0] RD_NR44_OR  = 8'hBF;
  localparam logic [7:0] RD_GATED    = 8'hFF;

  // Takes NRx2[7:3]; the DAC is powered whenever any of these bits is set.
  function automatic logic dac_on(input logic [4:0] env_hi);
    return |env_hi;
  endfunction

endpackage

// File: rtl/length_counter.sv
// Channel length counter: loads 2**LEN_W - value, reloads full scale when triggered at zero,
// and counts down on enabled ticks, flagging the tick that reaches zero.
module length_counter #(
  parameter int unsigned LEN_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             reload,
  input  logic             tick,
  input  logic             enable,
  output logic             expired
);

  localparam logic [LEN_W:0] FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0] ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] ZERO = '0;

  logic [LEN_W:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = ZERO;
    end else if (load) begin
      count_d = FULL - {1'b0, load_val};
    end else if (reload && (count_q == ZERO)) begin
      count_d = FULL;
    end else if (tick && enable && (count_q != ZERO)) begin
      count_d = count_q - ONE;
    end
  end

  assign expired = !clear && !load && tick && enable && (count_q == ONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= ZERO;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ch4_register_interface.sv
// Noise channel register file (NR41..NR44) with length counter and trigger strobe.
// Optional SOUND_MASTER_GATE_EN adds a sound_on input that holds everything in reset.
module ch4_register_interface
  import apu_pkg::*;
#(
  parameter int unsigned LEN_W    = 6,
  parameter logic [7:0]  NR42_RST = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
`ifdef SOUND_MASTER_GATE_EN
  input  logic       sound_on,
`endif
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [1:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  input  logic       length_tick,
  output logic [7:0] NRx2,
  output logic [7:0] NRx3,
  output logic       trigger,
  output logic       channel_on
);

  logic gate_open;
`ifdef SOUND_MASTER_GATE_EN
  assign gate_open = sound_on;
`else
  assign gate_open = 1'b1;
`endif

  logic [7:0] nrx2_q, nrx2_d, nrx3_q, nrx3_d, rd_data_q, rd_data_d;
  logic       len_en_q, len_en_d, trigger_q, trigger_d, channel_on_q, channel_on_d;
  logic       wr_nr41, wr_nr42, wr_nr43, wr_nr44, trig_accept, tick_eff, len_expired;
  reg_offset_t off;

  assign off         = reg_offset_t'(addr);
  assign wr_nr41     = wr_en && gate_open && (off == NR41);
  assign wr_nr42     = wr_en && gate_open && (off == NR42);
  assign wr_nr43     = wr_en && gate_open && (off == NR43);
  assign wr_nr44     = wr_en && gate_open && (off == NR44);
  assign trig_accept = wr_nr44 && wr_data[7] && dac_on(nrx2_q[7:3]);
  // NR41/NR44 writes take priority over the frame-sequencer tick.
  assign tick_eff    = length_tick && gate_open && !wr_nr41 && !wr_nr44;

  length_counter #(
    .LEN_W(LEN_W)
  ) u_len (
    .clock   (clock),
    .reset   (reset),
    .clear   (!gate_open),
    .load    (wr_nr41),
    .load_val(wr_data[LEN_W-1:0]),
    .reload  (trig_accept),
    .tick    (tick_eff),
    .enable  (len_en_q),
    .expired (len_expired)
  );

  always_comb begin
    nrx2_d       = nrx2_q;
    nrx3_d       = nrx3_q;
    len_en_d     = len_en_q;
    trigger_d    = trig_accept;
    channel_on_d = channel_on_q;
    rd_data_d    = rd_data_q;

    if (wr_nr42) nrx2_d = wr_data;
    if (wr_nr43) nrx3_d = wr_data;
    if (wr_nr44) len_en_d = wr_data[6];

    if (len_expired) channel_on_d = 1'b0;
    if (wr_nr42 && !dac_on(wr_data[7:3])) channel_on_d = 1'b0;
    if (trig_accept) channel_on_d = 1'b1;

    // Reads sample the pre-write register values.
    if (rd_en) begin
      if (!gate_open) begin
        rd_data_d = RD_GATED;
      end else begin
        unique case (off)
          NR41:    rd_data_d = RD_NR41_VAL;
          NR42:    rd_data_d = nrx2_q;
          NR43:    rd_data_d = nrx3_q;
          NR44:    rd_data_d = RD_NR44_OR | {1'b0, len_en_q, 6'b0};
          default: rd_data_d = RD_NR41_VAL;
        endcase
      end
    end

    if (!gate_open) begin
      nrx2_d       = NR42_RST;
      nrx3_d       = 8'h00;
      len_en_d     = 1'b0;
      trigger_d    = 1'b0;
      channel_on_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nrx2_q       <= NR42_RST;
      nrx3_q       <= 8'h00;
      rd_data_q    <= 8'h00;
      len_en_q     <= 1'b0;
      trigger_q    <= 1'b0;
      channel_on_q <= 1'b0;
    end else begin
      nrx2_q       <= nrx2_d;
      nrx3_q       <= nrx3_d;
      rd_data_q    <= rd_data_d;
      len_en_q     <= len_en_d;
      trigger_q    <= trigger_d;
      channel_on_q <= channel_on_d;
    end
  end

  assign NRx2       = nrx2_q;
  assign NRx3       = nrx3_q;
  assign rd_data    = rd_data_q;
  assign trigger    = trigger_q;
  assign channel_on = channel_on_q;

endmodule
